blink_tick_ctrl: RTL

- Upstream control stage for the board LED pattern blocks.
- Synchronises and debounces two active-low push buttons.
- Button 0 steps a 2-bit blink-speed setting; button 1 toggles pause.
- Emits a single-cycle TICK strobe at the selected period. The downstream LED pattern stage advances one step per TICK instead of running its own free counter.

---
 rtl/blink_tick_ctrl_if.sv | 11 +
 rtl/blink_tick_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/blink_tick_ctrl_if.sv
// rtl/blink_tick_ctrl_if.sv - button inputs and blink control outputs of blink_tick_ctrl
interface blink_tick_ctrl_if;
  logic [1:0] KEY;
  logic       TICK;
  logic [1:0] SPEED;
  logic       PAUSED;
  logic [1:0] KEY_HELD;

  modport master (output KEY, input TICK, SPEED, PAUSED, KEY_HELD);
  modport slave  (input KEY, output TICK, SPEED, PAUSED, KEY_HELD);
endinterface

// File: rtl/blink_tick_ctrl.sv
// rtl/blink_tick_ctrl.sv - button debounce, speed/pause control and blink TICK strobe generator
// Optional macro KEY_REPEAT_EN: auto-repeat speed steps while KEY[0] stays held.
module blink_tick_ctrl #(
  parameter int BASE_PERIOD     = 25000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  blink_tick_ctrl_if.slave bus
);
  typedef enum logic [1:0] {REL, PRESS_CHK, HELD, REL_CHK} deb_state_e;

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
  localparam bit          CFG_OK   = (BASE_PERIOD >= 16) && (DEBOUNCE_CYCLES >= 1) &&
                                     (REPEAT_CYCLES >= 1);

  if (!CFG_OK) begin : g_cfg_err
    $error("blink_tick_ctrl: BASE_PERIOD must be >=16, DEBOUNCE/REPEAT cycles >=1");
  end

  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  w_key_dn;
  logic [1:0]  w_press;
  logic [1:0]  w_held;
  logic        w_speed_step;
  logic        w_pause_step;
  logic [1:0]  r_speed;
  logic        r_paused;
  logic        r_tick;
  logic [31:0] r_tcnt;
  logic [31:0] w_limit;

  // Two-flop synchroniser; released (1) out of reset so a key held through reset reads as a new press.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= bus.KEY;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_dn = ~r_sync2;

  for (genvar g = 0; g < 2; g++) begin : g_deb
    deb_state_e  r_state;
    deb_state_e  w_state_nxt;
    logic [31:0] r_dcnt;
    logic [31:0] w_dcnt_nxt;
    logic        w_pulse;

    always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
        r_state <= REL;
        r_dcnt  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_dcnt  <= w_dcnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_pulse     = 1'b0;
      case (r_state)
        REL: begin
          if (w_key_dn[g]) begin
            w_state_nxt = PRESS_CHK;
            w_dcnt_nxt  = '0;
          end
        end
        PRESS_CHK: begin
          if (!w_key_dn[g]) begin
            w_state_nxt = REL;
          end else if (r_dcnt == DEB_LAST) begin
            w_state_nxt = HELD;
            w_pulse     = 1'b1;
          end else begin
            w_dcnt_nxt = r_dcnt + 32'd1;
          end
        end
        HELD: begin
          if (!w_key_dn[g]) begin
            w_state_nxt = REL_CHK;
            w_dcnt_nxt  = '0;
          end
        end
        REL_CHK: begin
          if (w_key_dn[g]) begin
            w_state_nxt = HELD;
          end else if (r_dcnt == DEB_LAST) begin
            w_state_nxt = REL;
          end else begin
            w_dcnt_nxt = r_dcnt + 32'd1;
          end
        end
        default: w_state_nxt = REL;
      endcase
    end

    assign w_press[g] = w_pulse;
    assign w_held[g]  = (r_state == HELD) || (r_state == REL_CHK);
  end

`ifdef KEY_REPEAT_EN
  localparam logic [31:0] REP_LAST = 32'(REPEAT_CYCLES - 1);

  logic [31:0] r_rcnt;
  logic        w_rep_pulse;

  // Counter saturates during a release bounce so a due repeat fires once the key settles back.
  assign w_rep_pulse = (g_deb[0].r_state == HELD) && w_key_dn[0] && (r_rcnt == REP_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N || !w_held[0]) begin
      r_rcnt <= '0;
    end else if (w_rep_pulse) begin
      r_rcnt <= '0;
    end else if (r_rcnt != REP_LAST) begin
      r_rcnt <= r_rcnt + 32'd1;
    end
  end

  assign w_speed_step = w_press[0] | w_rep_pulse;
`else
  assign w_speed_step = w_press[0];
`endif

  assign w_pause_step = w_press[1];
  assign w_limit      = (32'(BASE_PERIOD) >> r_speed) - 32'd1;

  // A speed step restarts the period, so it also swallows a coinciding terminal count.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_speed  <= '0;
      r_paused <= 1'b0;
      r_tcnt   <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_pause_step) begin
        r_paused <= ~r_paused;
      end
      if (w_speed_step) begin
        r_speed <= r_speed + 2'd1;
        r_tcnt  <= '0;
      end else if (!r_paused) begin
        if (r_tcnt == w_limit) begin
          r_tcnt <= '0;
          r_tick <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + 32'd1;
        end
      end
    end
  end

  assign bus.TICK     = r_tick;
  assign bus.SPEED    = r_speed;
  assign bus.PAUSED   = r_paused;
  assign bus.KEY_HELD = w_held;
endmodule
